// File: rtl/router_pkg.sv
// Shared definitions for the sync router: default sizing, timer state
// encoding and the width helper used to size the per-channel counters.
package router_pkg;

    localparam int DEF_NUM_CH  = 3;
    localparam int DEF_TIMEOUT = 30;
    localparam int DEF_ADDR_W  = 2;

    typedef enum logic {
        TMR_WAIT  = 1'b0,
        TMR_COUNT = 1'b1
    } timer_state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2w(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/router_sync_n_if.sv
// Bundle of the router's handshake and status signals. The router sits on
// the slave side; whoever drives the packet FSM and FIFOs uses master.
interface router_sync_n_if
    import router_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic              addr_err;

    modport slave (
        input  detect_add,
        input  data_in,
        input  write_enb_reg,
        input  full,
        input  empty,
        input  read_enb,
        output write_enb,
        output fifo_full,
        output vld_out,
        output soft_reset,
        output addr_err
    );

    modport master (
        output detect_add,
        output data_in,
        output write_enb_reg,
        output full,
        output empty,
        output read_enb,
        input  write_enb,
        input  fifo_full,
        input  vld_out,
        input  soft_reset,
        input  addr_err
    );

endinterface

// File: rtl/router_sync_timer.sv
// Per-channel stall watchdog: counts consecutive cycles where the channel
// holds valid data nobody reads, and fires a one-cycle flush pulse when the
// count reaches TIMEOUT. The pulse cycle itself is never counted, so a
// permanently stalled channel pulses every TIMEOUT+1 cycles.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic read,
    output logic soft_reset
);

    localparam int             CNT_W = clog2w(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    timer_state_t     state;
    timer_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_q;
    logic             pulse_next;
    logic             expire;
    logic             qualify;

    assign qualify = vld & ~read;

    // State register: FSM state, stall counter and the registered pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= TMR_WAIT;
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pulse_q <= pulse_next;
        end
    end

    // Next state: leave WAIT on a stalled cycle unless we are mid-pulse,
    // fall back to WAIT on a read, loss of valid, or the final count.
    always_comb begin
        state_next = state;
        expire     = 1'b0;
        case (state)
            TMR_WAIT: begin
                if (qualify && !pulse_q) begin
                    state_next = TMR_COUNT;
                end
            end
            TMR_COUNT: begin
                if (!qualify) begin
                    state_next = TMR_WAIT;
                end else if (cnt == LAST) begin
                    state_next = TMR_WAIT;
                    expire     = 1'b1;
                end
            end
            default: state_next = TMR_WAIT;
        endcase
    end

    // Outputs: counter advances only while staying/entering COUNT, and the
    // flush pulse is registered from the expiry decision.
    always_comb begin
        cnt_next   = '0;
        pulse_next = expire;
        if (state_next == TMR_COUNT) begin
            cnt_next = cnt + 1'b1;
        end
        soft_reset = pulse_q;
    end

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the destination from the header, steers the
// write strobe and full flag to the selected FIFO, exposes per-channel
// valid, and runs one stall watchdog per output channel.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic           clock,
    input  logic           reset,
    router_sync_n_if.slave bus
);

    logic [ADDR_W-1:0] addr_reg;
    logic              addr_ok;
    logic              addr_err_q;
    logic              in_range;
    logic [NUM_CH-1:0] wen;
    logic              sel_full;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] soft_rst;

    assign in_range = (int'(bus.data_in) < NUM_CH);

    // Header capture: destination and its validity are held until the next
    // header; a bad destination raises the error flag for one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_reg   <= '0;
            addr_ok    <= 1'b1;
            addr_err_q <= 1'b0;
        end else if (bus.detect_add) begin
            addr_reg   <= bus.data_in;
            addr_ok    <= in_range;
            addr_err_q <= ~in_range;
        end else begin
            addr_err_q <= 1'b0;
        end
    end

    // Destination decode from the latched address: one-hot write strobe and
    // the matching FIFO's full flag; an invalid address selects nothing.
    always_comb begin
        wen      = '0;
        sel_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ok && (int'(addr_reg) == i)) begin
                wen[i]   = bus.write_enb_reg;
                sel_full = bus.full[i];
            end
        end
    end

    assign vld            = ~bus.empty;
    assign bus.vld_out    = vld;
    assign bus.write_enb  = wen;
    assign bus.fifo_full  = sel_full;
    assign bus.addr_err   = addr_err_q;
    assign bus.soft_reset = soft_rst;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_tmr
        router_sync_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_tmr (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld[g]),
            .read       (bus.read_enb[g]),
            .soft_reset (soft_rst[g])
        );
    end

endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 Parameter NUM_CH, default 3, number of output channels (legal 2..8).
REQ-002 Parameter TIMEOUT, default 30, consecutive unread-valid cycles before soft reset (legal 2..255).
REQ-003 Parameter ADDR_W, default 2, address width; SHALL satisfy 2**ADDR_W >= NUM_CH.
REQ-004 clock  in  1  single clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 detect_add  in  1  header cycle; latch data_in as destination.
REQ-007 data_in  in  ADDR_W  destination address from header byte.
REQ-008 write_enb_reg  in  1  FSM write strobe for the current packet.
REQ-009 full  in  NUM_CH  per-FIFO full flags.
REQ-010 empty  in  NUM_CH  per-FIFO empty flags.
REQ-011 read_enb  in  NUM_CH  per-channel read strobes from the output side.
REQ-012 write_enb  out  NUM_CH  one-hot FIFO write enables.
REQ-013 fifo_full  out  1  full flag of the selected FIFO.
REQ-014 vld_out  out  NUM_CH  per-channel data-valid.
REQ-015 soft_reset  out  NUM_CH  per-channel timeout flush pulse.
REQ-016 addr_err  out  1  one-cycle pulse: latched address >= NUM_CH.

Function
REQ-017 On a rising edge with detect_add=1, addr_reg SHALL load data_in and addr_ok SHALL load (data_in < NUM_CH); otherwise both hold.
REQ-018 addr_err SHALL be registered, high for exactly the one cycle after an edge that latched an out-of-range address.
REQ-019 write_enb SHALL be combinational: one-hot at bit addr_reg when write_enb_reg=1 and addr_ok=1; all zeros otherwise (including write_enb_reg=1 with invalid address).
REQ-020 write_enb SHALL use the registered address; in the detect_add cycle itself it reflects the previously latched address.
REQ-021 fifo_full SHALL be combinational: full[addr_reg] when addr_ok=1, else 0.
REQ-022 vld_out[i] SHALL equal ~empty[i], combinational, zero latency.
REQ-023 Each channel SHALL own a counter of width clog2(TIMEOUT); it clears when vld_out[i]=0 or read_enb[i]=1, else increments.
REQ-024 Each channel timer SHALL be a two-state FSM: WAIT (counter clear) -> COUNT when vld_out[i]=1 and read_enb[i]=0; COUNT -> WAIT on vld_out[i]=0 or read_enb[i]=1.
REQ-025 When the TIMEOUT-th consecutive qualifying cycle ends, soft_reset[i] SHALL go high (registered) for exactly one cycle, the counter SHALL clear and the FSM SHALL return to WAIT.
REQ-026 If vld_out[i] remains 1 and unread after a soft reset, a fresh TIMEOUT-cycle count SHALL begin; soft_reset[i] therefore pulses every TIMEOUT+1 cycles.
REQ-027 read_enb[i]=1 in the cycle the count would reach TIMEOUT SHALL suppress the pulse.
REQ-028 Channel timers SHALL be independent; simultaneous pulses on several channels are legal.
REQ-029 Counter SHALL never wrap: saturation is impossible because it clears at TIMEOUT.

Reset
REQ-030 reset=1 SHALL asynchronously clear addr_reg to 0, addr_ok to 1, addr_err to 0, all counters to 0, all FSMs to WAIT, soft_reset to 0.
REQ-031 Reset asserted mid-count SHALL discard the count; no soft_reset pulse SHALL follow release.
REQ-032 Combinational outputs SHALL follow their definitions during reset (write_enb with addr 0, vld_out from empty).

Structure
REQ-033 Shared package router_pkg SHALL hold NUM_CH and TIMEOUT defaults, the clog2 width function and the timer state encoding.
REQ-034 Per-channel timer SHALL be sub-module router_sync_timer (ports clock, reset, vld, read, soft_reset; parameter TIMEOUT), instantiated NUM_CH times via generate.

Verification
REQ-035 NUM_CH=3: detect_add=1, data_in=2, then write_enb_reg=1 -> write_enb=3'b100 from next cycle; fifo_full tracks full[2].
REQ-036 detect_add=1, data_in=3 -> addr_err high one cycle; write_enb=3'b000, fifo_full=0 with write_enb_reg=1.
REQ-037 empty_0=0, read_enb_0=0 held, TIMEOUT=30 -> soft_reset[0] single pulse after 30 cycles, repeats 31 cycles later.
REQ-038 Same as REQ-037 with read_enb_0=1 at cycle 29 -> no pulse; count restarts from 0.
REQ-039 reset pulsed at cycle 20 of a count -> no soft_reset, counters 0, addr_reg 0.
REQ-040 empty=3'b000, no reads -> soft_reset=3'b111 simultaneously after 30 cycles.
